// File: rtl/shift_pkg.sv
// Shared definitions for the sequential barrel left-shifter.
// This package holds the state encoding and the default datapath sizes.
package shift_pkg;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sll_stage.sv
// One barrel-shifter stage. When enable_i is high, the output is value_i shifted
// left by 2^stage_i. Otherwise the output is value_i unchanged.
module sll_stage #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             enable_i,
    input  logic [IDX_W-1:0] stage_i,
    output logic [WIDTH-1:0] value_o
);

    logic [31:0] amount;

    always_comb begin
        amount  = 32'd1 << stage_i;
        value_o = enable_i ? (value_i << amount) : value_i;
    end

endmodule

// File: rtl/sll_seq.sv
// Multi-cycle logical left shifter. It applies one power-of-two stage per cycle,
// so the latency is fixed at STAGES cycles whatever the shift amount is.
module sll_seq #(
    parameter int WIDTH  = shift_pkg::WIDTH,
    parameter int STAGES = shift_pkg::STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  Shift_In,
    input  logic [STAGES-1:0] Shift_Val,
    output logic [WIDTH-1:0]  Shift_Out,
    output logic              busy,
    output logic              done
);
    import shift_pkg::*;

    localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [WIDTH-1:0]  shift_out_q, shift_out_d;
    logic [STAGES-1:0] amt_q, amt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  stage_val;

    // A single stage is shared across all cycles; the counter selects its weight.
    sll_stage #(
        .WIDTH (WIDTH),
        .IDX_W (CW)
    ) u_stage (
        .value_i  (work_q),
        .enable_i (amt_q[cnt_q]),
        .stage_i  (cnt_q),
        .value_o  (stage_val)
    );

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        shift_out_d = shift_out_q;
        amt_d       = amt_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    work_d  = Shift_In;
                    amt_d   = Shift_Val;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = stage_val;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(STAGES - 1)) begin
                    state_d     = DONE;
                    shift_out_d = stage_val;
                    cnt_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            shift_out_q <= '0;
            amt_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            shift_out_q <= shift_out_d;
            amt_q       <= amt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Shift_Out = shift_out_q;
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);

endmodule

// File: doc/sll_seq.md
SLL_SEQ -- requirements
Module: sll_seq

Interface
REQ-001 Parameter WIDTH, default 16, data path width in bits.
REQ-002 Parameter STAGES, default 4, shift-amount width and number of shift cycles (log2 WIDTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-006 Shift_In  input  WIDTH  operand to be shifted left.
REQ-007 Shift_Val  input  STAGES  unsigned left-shift amount, 0..15.
REQ-008 Shift_Out  output  WIDTH  registered result of the logical left shift.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking a new valid Shift_Out.

Function
REQ-011 The result SHALL be Shift_In << Shift_Val (logical), with zero fill from the LSB and bits shifted past bit WIDTH-1 discarded.
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture Shift_In and Shift_Val into internal registers, clear the stage counter to 0 and enter SHIFT.
REQ-014 In SHIFT, each cycle SHALL apply stage k = counter: the working value is shifted left by 2^k if captured Shift_Val[k]=1, and held otherwise.
REQ-015 The counter SHALL then increment; after stage STAGES-1 the FSM SHALL enter DONE and load the working value into Shift_Out.
REQ-016 Latency SHALL be fixed: done goes high exactly STAGES cycles (4) after the edge that samples start, independent of Shift_Val, including Shift_Val=0.
REQ-017 busy SHALL be 1 exactly while in SHIFT.
REQ-018 done SHALL be 1 exactly while in DONE, and DONE SHALL last one cycle.
REQ-019 From DONE, the FSM SHALL go to IDLE when start=0 and to SHIFT when start=1 (back-to-back operation, no bubble).
REQ-020 start while busy=1 SHALL be ignored; the captured operands SHALL NOT change.
REQ-021 Shift_In and Shift_Val SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.
REQ-022 Shift_Out SHALL hold its previous result through IDLE and SHIFT and change only on the transition into DONE.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, Shift_Out=0, busy=0, done=0, counter=0, working and captured registers=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow release of reset.
REQ-025 The first start after reset release SHALL be accepted normally.

Structure
REQ-026 A shared package shift_pkg SHALL hold the state encoding (IDLE, SHIFT, DONE) and the constants WIDTH=16 and STAGES=4.
REQ-027 The single-stage combinational step SHALL live in one sub-module, sll_stage (inputs: value, enable, stage index; output: value shifted by 2^index or passed through), instantiated once and reused each cycle.
REQ-028 All sequential logic SHALL reside in sll_seq; no other sub-modules.

Verification
REQ-029 Shift_In=0x0001, Shift_Val=15, start pulse -> done exactly 4 cycles later, Shift_Out=0x8000, busy high for those 4 cycles.
REQ-030 Shift_In=0xABCD, Shift_Val=4 -> Shift_Out=0xBCD0; Shift_In=0x8001, Shift_Val=1 -> 0x0002 (zero fill, no sign retention).
REQ-031 Shift_In=0x1234, Shift_Val=0 -> done after 4 cycles, Shift_Out=0x1234.
REQ-032 Start 0x00FF/val 8; pulse start again at cycle 2 with 0xFFFF/val 1; change Shift_In after the first accept -> result 0xFF00, one done pulse only.
REQ-033 start held high continuously with 0x0003/val 2 -> done every 5th cycle (4 SHIFT + 1 DONE), Shift_Out=0x000C each time.
REQ-034 rst_n low during the 2nd SHIFT cycle -> Shift_Out, busy and done 0 at once, no done after release; next op 0x0F0F/val 4 -> 0xF0F0.
